// File: rtl/sdram_rw_arbiter.sv
// Burst request scheduler in front of the SDRAM controller: watches both FIFO
// fill levels, runs the req/ack handshake and walks two frame-buffer pointers.
module sdram_rw_arbiter #(
    parameter logic [8:0]         BURST       = 9'd256,
    parameter logic [21:0]        ADDR_BASE   = 22'd0,
    parameter logic [21:0]        FRAME_WORDS = 22'd307200,
    parameter int unsigned        FIFO_AW     = 10,
    parameter logic [FIFO_AW-1:0] RD_THR      = 10'd256
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               sdram_init_done,
    input  logic [FIFO_AW-1:0] wrfifo_usedw,
    input  logic [FIFO_AW-1:0] rdfifo_usedw,
    input  logic               wr_frame_start,
    input  logic               rd_frame_start,
    output logic               sdram_wr_req,
    output logic               sdram_rd_req,
    input  logic               sdram_wr_ack,
    input  logic               sdram_rd_ack,
    output logic [21:0]        sys_wraddr,
    output logic [21:0]        sys_rdaddr,
    output logic [8:0]         sdwr_byte,
    output logic [8:0]         sdrd_byte,
    output logic               busy
);

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_BUSY,
        RD_REQ,
        RD_BUSY
    } state_t;

    // One bit wider than the address so an end at exactly 2^22 still compares correctly.
    localparam logic [22:0] ADDR_END = {1'b0, ADDR_BASE} + {1'b0, FRAME_WORDS};

    state_t      state, state_d;
    logic        wr_req_q, wr_req_d;
    logic        rd_req_q, rd_req_d;
    logic [21:0] wraddr_q, wraddr_d;
    logic [21:0] rdaddr_q, rdaddr_d;
    logic        wr_pend_q, wr_pend_d;
    logic        rd_pend_q, rd_pend_d;

    logic        rd_eligible;
    logic        wr_eligible;
    logic [22:0] wr_next;
    logic [22:0] rd_next;

    assign rd_eligible = (rdfifo_usedw < RD_THR);
    assign wr_eligible = ({1'b0, wrfifo_usedw} >= (FIFO_AW + 1)'(BURST));
    assign wr_next     = {1'b0, wraddr_q} + {14'd0, BURST};
    assign rd_next     = {1'b0, rdaddr_q} + {14'd0, BURST};

    always_comb begin
        // NOTE: every comb output gets a default first, so no path can infer a latch.
        state_d   = state;
        wr_req_d  = wr_req_q;
        rd_req_d  = rd_req_q;
        wraddr_d  = wraddr_q;
        rdaddr_d  = rdaddr_q;
        wr_pend_d = wr_pend_q | wr_frame_start;
        rd_pend_d = rd_pend_q | rd_frame_start;

        unique case (state)
            IDLE: begin
                // A pending frame restart takes the whole IDLE cycle; no request alongside it.
                if (wr_pend_d || rd_pend_d) begin
                    if (wr_pend_d) begin
                        wraddr_d  = ADDR_BASE;
                        wr_pend_d = 1'b0;
                    end
                    if (rd_pend_d) begin
                        rdaddr_d  = ADDR_BASE;
                        rd_pend_d = 1'b0;
                    end
                end else if (sdram_init_done) begin
                    if (rd_eligible) begin
                        state_d  = RD_REQ;
                        rd_req_d = 1'b1;
                    end else if (wr_eligible) begin
                        state_d  = WR_REQ;
                        wr_req_d = 1'b1;
                    end
                end
            end
            WR_REQ: begin
                if (sdram_wr_ack) begin
                    wr_req_d = 1'b0;
                    state_d  = WR_BUSY;
                end
            end
            WR_BUSY: begin
                if (!sdram_wr_ack) begin
                    state_d = IDLE;
                    if (wr_pend_d) begin
                        wraddr_d  = ADDR_BASE;
                        wr_pend_d = 1'b0;
                    end else begin
                        wraddr_d = (wr_next >= ADDR_END) ? ADDR_BASE : wr_next[21:0];
                    end
                end
            end
            RD_REQ: begin
                if (sdram_rd_ack) begin
                    rd_req_d = 1'b0;
                    state_d  = RD_BUSY;
                end
            end
            RD_BUSY: begin
                if (!sdram_rd_ack) begin
                    state_d = IDLE;
                    if (rd_pend_d) begin
                        rdaddr_d  = ADDR_BASE;
                        rd_pend_d = 1'b0;
                    end else begin
                        rdaddr_d = (rd_next >= ADDR_END) ? ADDR_BASE : rd_next[21:0];
                    end
                end
            end
            default: begin
                state_d  = IDLE;
                wr_req_d = 1'b0;
                rd_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
        if (!rst_n) begin
            state     <= IDLE;
            wr_req_q  <= 1'b0;
            rd_req_q  <= 1'b0;
            wraddr_q  <= ADDR_BASE;
            rdaddr_q  <= ADDR_BASE;
            wr_pend_q <= 1'b0;
            rd_pend_q <= 1'b0;
        end else begin
            state     <= state_d;
            wr_req_q  <= wr_req_d;
            rd_req_q  <= rd_req_d;
            wraddr_q  <= wraddr_d;
            rdaddr_q  <= rdaddr_d;
            wr_pend_q <= wr_pend_d;
            rd_pend_q <= rd_pend_d;
        end
    end

    assign sdram_wr_req = wr_req_q;
    assign sdram_rd_req = rd_req_q;
    assign sys_wraddr   = wraddr_q;
    assign sys_rdaddr   = rdaddr_q;
    assign sdwr_byte    = BURST;
    assign sdrd_byte    = BURST;
    assign busy         = (state != IDLE);

endmodule

// File: tb/tb_sdram_rw_arbiter.sv
// Directed bench for sdram_rw_arbiter: plays the controller side of the
// handshake and checks requests and burst addresses against hand-computed values.
module tb_sdram_rw_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sdram_init_done;
    logic [9:0]  wrfifo_usedw;
    logic [9:0]  rdfifo_usedw;
    logic        wr_frame_start;
    logic        rd_frame_start;
    logic        sdram_wr_req;
    logic        sdram_rd_req;
    logic        sdram_wr_ack;
    logic        sdram_rd_ack;
    logic [21:0] sys_wraddr;
    logic [21:0] sys_rdaddr;
    logic [8:0]  sdwr_byte;
    logic [8:0]  sdrd_byte;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;

    sdram_rw_arbiter dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .sdram_init_done (sdram_init_done),
        .wrfifo_usedw    (wrfifo_usedw),
        .rdfifo_usedw    (rdfifo_usedw),
        .wr_frame_start  (wr_frame_start),
        .rd_frame_start  (rd_frame_start),
        .sdram_wr_req    (sdram_wr_req),
        .sdram_rd_req    (sdram_rd_req),
        .sdram_wr_ack    (sdram_wr_ack),
        .sdram_rd_ack    (sdram_rd_ack),
        .sys_wraddr      (sys_wraddr),
        .sys_rdaddr      (sys_rdaddr),
        .sdwr_byte       (sdwr_byte),
        .sdrd_byte       (sdrd_byte),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Plays one controller burst: waits for req, raises ack after `delay`
    // cycles and holds it for `len` sampled edges.
    task automatic burst(input bit is_rd, input int delay, input int len, input logic [21:0] exp_addr);
        int waited = 0;
        while (!(is_rd ? sdram_rd_req : sdram_wr_req) && waited < 20) begin
            tick();
            waited++;
        end
        check("req_seen", {31'd0, is_rd ? sdram_rd_req : sdram_wr_req}, 32'd1);
        check("burst_addr", {10'd0, is_rd ? sys_rdaddr : sys_wraddr}, {10'd0, exp_addr});
        repeat (delay) tick();
        check("req_held", {31'd0, is_rd ? sdram_rd_req : sdram_wr_req}, 32'd1);
        if (is_rd) sdram_rd_ack = 1'b1; else sdram_wr_ack = 1'b1;
        tick();
        check("req_drop", {31'd0, is_rd ? sdram_rd_req : sdram_wr_req}, 32'd0);
        repeat (len - 1) tick();
        check("addr_hold", {10'd0, is_rd ? sys_rdaddr : sys_wraddr}, {10'd0, exp_addr});
        if (is_rd) sdram_rd_ack = 1'b0; else sdram_wr_ack = 1'b0;
        tick();
        check("gap_no_req", {30'd0, sdram_rd_req, sdram_wr_req}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen_req;
        rst_n           = 1'b0;
        sdram_init_done = 1'b0;
        wrfifo_usedw    = 10'd300;
        rdfifo_usedw    = 10'd0;
        wr_frame_start  = 1'b0;
        rd_frame_start  = 1'b0;
        sdram_wr_ack    = 1'b0;
        sdram_rd_ack    = 1'b0;
        repeat (2) @(negedge clk);

        check("rst_wr_req", {31'd0, sdram_wr_req}, 32'd0);
        check("rst_rd_req", {31'd0, sdram_rd_req}, 32'd0);
        check("rst_wraddr", {10'd0, sys_wraddr}, 32'd0);
        check("rst_rdaddr", {10'd0, sys_rdaddr}, 32'd0);
        check("rst_busy",   {31'd0, busy}, 32'd0);
        check("sdwr_byte",  {23'd0, sdwr_byte}, 32'd256);
        rst_n = 1'b1;

        // Init gating: both FIFOs eligible, but nothing may be requested.
        seen_req = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            seen_req = seen_req | sdram_wr_req | sdram_rd_req;
        end
        check("init_gate", {31'd0, seen_req}, 32'd0);

        sdram_init_done = 1'b1;
        tick();
        check("first_rd_req", {31'd0, sdram_rd_req}, 32'd1);
        check("first_wr_req", {31'd0, sdram_wr_req}, 32'd0);
        check("first_rdaddr", {10'd0, sys_rdaddr}, 32'd0);
        check("sdrd_byte",    {23'd0, sdrd_byte}, 32'd256);
        check("busy_req",     {31'd0, busy}, 32'd1);

        // Full-length handshake: ack 5 cycles after req, 256 data cycles.
        burst(1'b1, 5, 256, 22'd0);
        check("rdaddr_after_1", {10'd0, sys_rdaddr}, 32'd256);
        check("busy_idle",      {31'd0, busy}, 32'd0);

        // Priority: both eligible -> read first, then write.
        rdfifo_usedw = 10'd100;
        wrfifo_usedw = 10'd256;
        tick();
        check("prio_rd_req", {31'd0, sdram_rd_req}, 32'd1);
        check("prio_wr_req", {31'd0, sdram_wr_req}, 32'd0);
        burst(1'b1, 2, 4, 22'd256);
        check("rdaddr_after_2", {10'd0, sys_rdaddr}, 32'd512);
        rdfifo_usedw = 10'd400;
        burst(1'b0, 1, 4, 22'd0);
        check("wraddr_after_1", {10'd0, sys_wraddr}, 32'd256);

        // Frame start in IDLE: pointer to base next cycle, no request that cycle.
        wrfifo_usedw   = 10'd0;
        rdfifo_usedw   = 10'd0;
        rd_frame_start = 1'b1;
        tick();
        rd_frame_start = 1'b0;
        check("idle_fs_rdaddr", {10'd0, sys_rdaddr}, 32'd0);
        check("idle_fs_no_req", {30'd0, sdram_rd_req, sdram_wr_req}, 32'd0);

        // Wrap: 1200 bursts cover 307200 words, then back to 0.
        for (int i = 0; i < 1200; i++)
            burst(1'b1, 0, 1, 22'((i * 256) % 307200));
        check("wrap_rdaddr", {10'd0, sys_rdaddr}, 32'd0);

        for (int i = 0; i < 4; i++)
            burst(1'b1, 0, 1, 22'(i * 256));

        // Frame starts during a read burst: both held until the burst ends.
        tick();
        check("mid_rd_req",  {31'd0, sdram_rd_req}, 32'd1);
        check("mid_rdaddr",  {10'd0, sys_rdaddr}, 32'd1024);
        sdram_rd_ack = 1'b1;
        tick();
        tick();
        rd_frame_start = 1'b1;
        tick();
        rd_frame_start = 1'b0;
        wr_frame_start = 1'b1;
        tick();
        wr_frame_start = 1'b0;
        check("mid_rdaddr_hold", {10'd0, sys_rdaddr}, 32'd1024);
        check("mid_wraddr_hold", {10'd0, sys_wraddr}, 32'd256);
        repeat (3) tick();
        sdram_rd_ack = 1'b0;
        tick();
        check("end_rdaddr_base", {10'd0, sys_rdaddr}, 32'd0);
        check("end_wraddr_wait", {10'd0, sys_wraddr}, 32'd256);
        tick();
        check("pend_wraddr_base", {10'd0, sys_wraddr}, 32'd0);
        check("pend_no_req",      {30'd0, sdram_rd_req, sdram_wr_req}, 32'd0);
        burst(1'b1, 0, 2, 22'd0);
        check("rdaddr_after_fs", {10'd0, sys_rdaddr}, 32'd256);

        rdfifo_usedw = 10'd400;
        wrfifo_usedw = 10'd300;
        burst(1'b0, 0, 2, 22'd0);
        check("wraddr_after_fs", {10'd0, sys_wraddr}, 32'd256);

        // Asynchronous reset in the middle of a write burst.
        tick();
        check("wr_req_again", {31'd0, sdram_wr_req}, 32'd1);
        sdram_wr_ack = 1'b1;
        tick();
        tick();
        check("wr_busy", {31'd0, busy}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_wr_req", {31'd0, sdram_wr_req}, 32'd0);
        check("arst_rd_req", {31'd0, sdram_rd_req}, 32'd0);
        check("arst_busy",   {31'd0, busy}, 32'd0);
        check("arst_wraddr", {10'd0, sys_wraddr}, 32'd0);
        check("arst_rdaddr", {10'd0, sys_rdaddr}, 32'd0);
        tick();
        sdram_wr_ack = 1'b0;
        rst_n        = 1'b1;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
